// File: rtl/lab1_st_pkg.sv
// Shared types and helpers for the lab1_st_merge result-stream merger.
// Entry layout is {channel, data}; pointer wrap helper used by the FIFO.
package lab1_st_pkg;

  localparam int LAB1_DATA_W = 32;

  typedef logic chan_t;

  typedef struct packed {
    chan_t                  channel;
    logic [LAB1_DATA_W-1:0] data;
  } entry_t;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/lab1_st_fifo.sv
// First-word-fall-through FIFO of tagged entries with registered full/empty
// flags and an occupancy count; the head entry is always visible on rd_entry.
module lab1_st_fifo
  import lab1_st_pkg::*;
#(
  parameter type T     = entry_t,
  parameter int  DEPTH = 8,
  parameter int  CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  T                 wr_entry,
  input  logic             pop,
  output T                 rd_entry,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] level_nxt;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign rd_entry = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop) begin
      level_nxt = level + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      level_nxt = level - CNT_W'(1);
    end
  end

  // Flags are registered from the next level so downstream readies see no
  // combinational path from the pop side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= AW'(ptr_inc(32'(wr_ptr), DEPTH));
      end
      if (do_pop) begin
        rd_ptr <= AW'(ptr_inc(32'(rd_ptr), DEPTH));
      end
      level <= level_nxt;
      full  <= (level_nxt == CNT_W'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/lab1_st_merge.sv
// Round-robin merge of two ready/valid ALU result streams into one tagged
// FWFT stream. Optional counters enabled by LAB1_MERGE_STATS_EN.
module lab1_st_merge
  import lab1_st_pkg::*;
#(
  parameter int DATA_W = LAB1_DATA_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_channel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  fill_level
`ifdef LAB1_MERGE_STATS_EN
  ,
  output logic [31:0]       stat_cnt0,
  output logic [31:0]       stat_cnt1,
  output logic [31:0]       stat_stall
`endif
);

  typedef struct packed {
    chan_t             channel;
    logic [DATA_W-1:0] data;
  } merge_entry_t;

  chan_t        prio;
  logic         full;
  logic         empty;
  logic         acc0;
  logic         acc1;
  logic         push;
  merge_entry_t wr_entry;
  merge_entry_t rd_entry;

  // Priority channel sees ~full; the other also yields to a valid priority
  // channel. Readies are forced low while reset is held.
  assign in0_ready = reset_reset_n & ~full & (~prio | ~in1_valid);
  assign in1_ready = reset_reset_n & ~full & ( prio | ~in0_valid);

  assign acc0 = in0_valid & in0_ready;
  assign acc1 = in1_valid & in1_ready;
  assign push = acc0 | acc1;

  assign wr_entry.channel = acc1;
  assign wr_entry.data    = acc1 ? in1_data : in0_data;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      prio <= 1'b0;
    end else if (push) begin
      prio <= ~wr_entry.channel;
    end
  end

  lab1_st_fifo #(
    .T     (merge_entry_t),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .push     (push),
    .wr_entry (wr_entry),
    .pop      (out_ready),
    .rd_entry (rd_entry),
    .full     (full),
    .empty    (empty),
    .level    (fill_level)
  );

  assign out_valid   = ~empty;
  assign out_data    = rd_entry.data;
  assign out_channel = rd_entry.channel;

`ifdef LAB1_MERGE_STATS_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stat_cnt0  <= '0;
      stat_cnt1  <= '0;
      stat_stall <= '0;
    end else begin
      if (acc0) stat_cnt0 <= stat_cnt0 + 32'd1;
      if (acc1) stat_cnt1 <= stat_cnt1 + 32'd1;
      if (out_valid && !out_ready) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
